// File: rtl/wb_cache_pkg.sv
// wb_cache_pkg: FSM state codes and address field helpers shared by the cache.
// Helpers work on 32-bit values; callers narrow the result with a sized cast.
package wb_cache_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE      = 3'd0;
    localparam state_t LOOKUP    = 3'd1;
    localparam state_t WRITEBACK = 3'd2;
    localparam state_t ALLOCATE  = 3'd3;
    localparam state_t RESPOND   = 3'd4;

    function automatic logic [31:0] addr_tag(
        input logic [31:0] a,
        input int unsigned iw,
        input int unsigned ow
    );
        return a >> (iw + ow);
    endfunction

    function automatic logic [31:0] addr_index(
        input logic [31:0] a,
        input int unsigned iw,
        input int unsigned ow
    );
        return (a >> ow) & ((32'd1 << iw) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_offset(
        input logic [31:0] a,
        input int unsigned ow
    );
        return a & ((32'd1 << ow) - 32'd1);
    endfunction

endpackage

// File: rtl/wb_cache_if.sv
// wb_cache_if: CPU request/ack side and per-beat memory side of the cache.
// slave is the cache's view; master is the CPU/RAM environment's view.
interface wb_cache_if #(
    parameter int ADDR_W = 10,
    parameter int WORD_W = 10
);
    logic              cpu_req;
    logic              cpu_rw;
    logic [ADDR_W-1:0] cpu_addr;
    logic [WORD_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic              cpu_ack;
    logic [WORD_W-1:0] cpu_rdata;

    logic              mem_req;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  cpu_req, cpu_rw, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_ack, cpu_rdata,
        output mem_req, mem_rw, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output cpu_req, cpu_rw, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_ack, cpu_rdata,
        input  mem_req, mem_rw, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/wb_cache_line_array.sv
// wb_cache_line_array: tag/valid/dirty/data storage for the direct-mapped cache.
// One write port: word-granular data, whole-entry metadata; clear drops valid/dirty.
module wb_cache_line_array #(
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 1,
    parameter int TAG_W    = 5,
    parameter int WORD_W   = 10
) (
    input  logic                clk,
    input  logic                clear,
    input  logic [INDEX_W-1:0]  idx,
    input  logic [OFFSET_W-1:0] rd_off,
    output logic [TAG_W-1:0]    rd_tag,
    output logic                rd_valid,
    output logic                rd_dirty,
    output logic [WORD_W-1:0]   rd_word,
    input  logic                we_data,
    input  logic                we_meta,
    input  logic [OFFSET_W-1:0] wr_off,
    input  logic [WORD_W-1:0]   wr_word,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic                wr_valid,
    input  logic                wr_dirty
);
    localparam int LINES = 1 << INDEX_W;
    localparam int DEPTH = LINES << OFFSET_W;

    logic [TAG_W-1:0]  tags  [LINES];
    logic [WORD_W-1:0] words [DEPTH];
    logic [LINES-1:0]  valid;
    logic [LINES-1:0]  dirty;

    assign rd_tag   = tags[idx];
    assign rd_valid = valid[idx];
    assign rd_dirty = dirty[idx];
    assign rd_word  = words[{idx, rd_off}];

    always_ff @(posedge clk) begin
        if (we_data) begin
            words[{idx, wr_off}] <= wr_word;
        end
        if (we_meta) begin
            tags[idx] <= wr_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            valid <= '0;
            dirty <= '0;
        end else if (we_meta) begin
            valid[idx] <= wr_valid;
            dirty[idx] <= wr_dirty;
        end
    end

endmodule

// File: rtl/wb_cache.sv
// wb_cache: direct-mapped write-back, write-allocate cache with registered CPU ack.
// Define WB_CACHE_STATS_EN to add saturating hit_cnt/miss_cnt/wb_cnt outputs.
module wb_cache
    import wb_cache_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int WORD_W   = 10,
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 1
) (
    input  logic       clk,
    input  logic       rst,
    wb_cache_if.slave  bus
`ifdef WB_CACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt,
    output logic [31:0] wb_cnt
`endif
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam logic [OFFSET_W-1:0] LAST_BEAT = '1;

    state_t              state;
    logic                req_rw;
    logic [ADDR_W-1:0]   req_addr;
    logic [WORD_W-1:0]   req_wdata;
    logic [OFFSET_W-1:0] beat;
    logic                ack;
    logic [WORD_W-1:0]   rdata;

    logic [TAG_W-1:0]    req_tag;
    logic [TAG_W-1:0]    old_tag;
    logic [INDEX_W-1:0]  req_idx;
    logic [OFFSET_W-1:0] req_off;
    logic [OFFSET_W-1:0] rd_off;
    logic [OFFSET_W-1:0] wr_off;
    logic                old_valid;
    logic                old_dirty;
    logic                hit;
    logic                last_beat;
    logic [WORD_W-1:0]   rd_word;
    logic [WORD_W-1:0]   wr_word;
    logic                we_data;
    logic                we_meta;
    logic                wr_dirty;

    assign req_tag = TAG_W'(addr_tag(32'(req_addr), INDEX_W, OFFSET_W));
    assign req_idx = INDEX_W'(addr_index(32'(req_addr), INDEX_W, OFFSET_W));
    assign req_off = OFFSET_W'(addr_offset(32'(req_addr), OFFSET_W));

    assign hit       = old_valid && (old_tag == req_tag);
    assign last_beat = (beat == LAST_BEAT);
    // Write-back streams the victim line; every other state reads the requested word.
    assign rd_off    = (state == WRITEBACK) ? beat : req_off;

    wb_cache_line_array #(
        .INDEX_W  (INDEX_W),
        .OFFSET_W (OFFSET_W),
        .TAG_W    (TAG_W),
        .WORD_W   (WORD_W)
    ) u_lines (
        .clk      (clk),
        .clear    (rst),
        .idx      (req_idx),
        .rd_off   (rd_off),
        .rd_tag   (old_tag),
        .rd_valid (old_valid),
        .rd_dirty (old_dirty),
        .rd_word  (rd_word),
        .we_data  (we_data),
        .we_meta  (we_meta),
        .wr_off   (wr_off),
        .wr_word  (wr_word),
        .wr_tag   (req_tag),
        .wr_valid (1'b1),
        .wr_dirty (wr_dirty)
    );

    always_comb begin
        we_data  = 1'b0;
        we_meta  = 1'b0;
        wr_off   = req_off;
        wr_word  = req_wdata;
        wr_dirty = 1'b0;
        unique case (1'b1)
            (state == LOOKUP) && hit && req_rw: begin
                we_data  = 1'b1;
                we_meta  = 1'b1;
                wr_dirty = 1'b1;
            end
            (state == ALLOCATE) && bus.mem_ready: begin
                we_data = 1'b1;
                wr_off  = beat;
                wr_word = bus.mem_rdata;
            end
            (state == RESPOND): begin
                we_data  = req_rw;
                we_meta  = 1'b1;
                wr_dirty = req_rw;
            end
            default: ;
        endcase
    end

    assign bus.cpu_ready = (state == IDLE);
    assign bus.cpu_ack   = ack;
    assign bus.cpu_rdata = rdata;
    assign bus.mem_req   = (state == WRITEBACK) || (state == ALLOCATE);
    assign bus.mem_rw    = (state == WRITEBACK);

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (state == WRITEBACK) begin
            bus.mem_addr  = {old_tag, req_idx, beat};
            bus.mem_wdata = rd_word;
        end else if (state == ALLOCATE) begin
            bus.mem_addr = {req_tag, req_idx, beat};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_rw    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            beat      <= '0;
            ack       <= 1'b0;
            rdata     <= '0;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cpu_req) begin
                        req_rw    <= bus.cpu_rw;
                        req_addr  <= bus.cpu_addr;
                        req_wdata <= bus.cpu_wdata;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    beat <= '0;
                    if (hit) begin
                        ack   <= 1'b1;
                        rdata <= req_rw ? req_wdata : rd_word;
                        state <= IDLE;
                    end else if (old_valid && old_dirty) begin
                        state <= WRITEBACK;
                    end else begin
                        state <= ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ready) begin
                        beat <= beat + OFFSET_W'(1);
                        if (last_beat) state <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (bus.mem_ready) begin
                        beat <= beat + OFFSET_W'(1);
                        if (last_beat) state <= RESPOND;
                    end
                end
                RESPOND: begin
                    ack   <= 1'b1;
                    rdata <= req_rw ? req_wdata : rd_word;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else if (state == LOOKUP) begin
            if (hit) begin
                if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
            end else begin
                if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
                if (old_valid && old_dirty && (wb_cnt != '1)) begin
                    wb_cnt <= wb_cnt + 32'd1;
                end
            end
        end
    end
`endif

endmodule
